instruction_fetch: RTL and testbench

//  Producer side of the decode interface: generates the PC, fetches 32-bit

---
 rtl/instruction_fetch.sv | 138 +++++++++++++
 tb/tb_instruction_fetch.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: PC generation, credit-limited imem requests, response FIFO
// and decode-side valid/ready output, with branch redirect that flushes stale work.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_inst,
  output logic [63:0] if_pc,
  input  logic        branch_taken,
  input  logic [63:0] branch_target
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {ST_START, ST_FETCH, ST_FLUSH} state_t;

  state_t        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [63:0]   resp_pc_q, resp_pc_d;
  logic [OW-1:0] outstanding_q, outstanding_d;
  logic [OW-1:0] drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [95:0]   fifo_mem [FIFO_DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [63:0]   redirect_pc;

  always_comb begin
    redirect_pc    = branch_target & ~64'h3;
    if_valid       = (count_q != '0);
    {if_inst, if_pc} = if_valid ? fifo_mem[rd_ptr_q] : 96'h0;

    // Credit rule: never have more requests in flight than free FIFO slots.
    imem_req_valid = (state_q == ST_FETCH) && !branch_taken
                     && (32'(outstanding_q) < MAX_OUTSTANDING)
                     && (32'(outstanding_q) + 32'(count_q) < FIFO_DEPTH);
    imem_req_addr  = pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    push           = imem_resp_valid && (drop_cnt_q == '0) && !branch_taken;
    pop            = if_valid && if_ready && !branch_taken;

    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (req_fire)
      pc_d = pc_q + 64'd4;
    if (req_fire && !imem_resp_valid)
      outstanding_d = outstanding_q + OW'(1);
    else if (!req_fire && imem_resp_valid)
      outstanding_d = outstanding_q - OW'(1);
    if (imem_resp_valid && (drop_cnt_q != '0))
      drop_cnt_d = drop_cnt_q - OW'(1);

    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      resp_pc_d = resp_pc_q + 64'd4;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Everything still in flight after this cycle's response becomes stale.
    if (branch_taken) begin
      pc_d       = redirect_pc;
      resp_pc_d  = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_cnt_d = outstanding_d;
    end

    case (state_q)
      ST_START: state_d = ST_FETCH;
      ST_FETCH: if (branch_taken && (outstanding_d != '0)) state_d = ST_FLUSH;
      ST_FLUSH: if (drop_cnt_d == '0) state_d = ST_FETCH;
      default:  state_d = ST_START;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_START;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_q] <= {imem_resp_data, resp_pc_q};
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == CW'(FIFO_DEPTH))));
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a transaction-level
// model: in-order memory queue tagged with redirect epochs, buffered-count tracking.
module tb_instruction_fetch;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        branch_taken;
  logic [63:0] branch_target;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(64'h0), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .branch_taken(branch_taken), .branch_target(branch_target)
  );

  typedef struct { logic [63:0] addr; int due; int epoch; } rsp_t;
  rsp_t mq[$];

  int n_checks = 0, n_fail = 0;
  int cyc, epoch, fifo_n, n_req, n_deliv, first_valid_cyc;
  int lat_min = 1, lat_max = 1;
  logic [63:0] exp_if_pc, exp_req_addr, last_req_addr, last_deliv_pc, last_addr, last_ifpc;
  bit last_rv, last_ifv;
  logic [31:0] salt = 32'h0;

  function automatic logic [31:0] memfn(input logic [63:0] a);
    return a[31:0] ^ salt;
  endfunction

  task automatic zero_inputs();
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    if_ready = 0; branch_taken = 0; branch_target = '0;
  endtask

  task automatic assert_reset();
    rst_n = 0;
    zero_inputs();
    mq.delete();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    cyc = 0; epoch = 0; fifo_n = 0; n_req = 0; n_deliv = 0; first_valid_cyc = -1;
    exp_if_pc = 64'h0; exp_req_addr = 64'h0;
  endtask

  // One clock cycle; entered and left at the falling edge.
  task automatic do_cycle(input bit br, input logic [63:0] tgt, input bit rq_rdy, input bit ifr);
    int   stale_n;
    int   outst;
    bit   exp_rv;
    bit   rsp_v;
    rsp_t rsp;
    rsp_t nr;
    stale_n = 0;
    foreach (mq[i]) if (mq[i].epoch != epoch) stale_n++;
    outst  = mq.size();
    exp_rv = (cyc > 0) && (stale_n == 0) && !br && (outst < MAXO) && (outst + fifo_n < DEPTH);
    imem_req_ready = rq_rdy; if_ready = ifr; branch_taken = br; branch_target = tgt;
    imem_resp_valid = 0; imem_resp_data = '0; rsp_v = 0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rsp = mq.pop_front();
      rsp_v = 1;
      imem_resp_valid = 1;
      imem_resp_data = memfn(rsp.addr);
    end
    #1;
    last_rv = imem_req_valid; last_addr = imem_req_addr; last_ifv = if_valid; last_ifpc = if_pc;
    if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    n_checks++;
    if (imem_req_valid !== exp_rv) begin
      n_fail++; $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, exp_rv);
    end
    n_checks++;
    if (if_valid !== (fifo_n > 0)) begin
      n_fail++; $display("FAIL if_valid cyc=%0d got=%b exp=%b", cyc, if_valid, fifo_n > 0);
    end
    if (imem_req_valid && rq_rdy) begin
      n_checks++;
      if (imem_req_addr !== exp_req_addr) begin
        n_fail++; $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, exp_req_addr);
      end
      nr.addr = imem_req_addr; nr.due = cyc + $urandom_range(lat_max, lat_min); nr.epoch = epoch;
      mq.push_back(nr);
      exp_req_addr = exp_req_addr + 64'd4;
      last_req_addr = imem_req_addr;
      n_req++;
    end
    if (if_valid && ifr && !br) begin
      $display("deliver cyc=%0d pc=%h inst=%h", cyc, if_pc, if_inst);
      n_checks++;
      if (if_pc !== exp_if_pc) begin
        n_fail++; $display("FAIL if_pc cyc=%0d got=%h exp=%h", cyc, if_pc, exp_if_pc);
      end
      n_checks++;
      if (if_inst !== memfn(exp_if_pc)) begin
        n_fail++; $display("FAIL if_inst cyc=%0d got=%h exp=%h", cyc, if_inst, memfn(exp_if_pc));
      end
      last_deliv_pc = if_pc;
      exp_if_pc = exp_if_pc + 64'd4;
      if (fifo_n > 0) fifo_n--;
      n_deliv++;
    end
    if (rsp_v && rsp.epoch == epoch && !br) fifo_n++;
    if (br) begin
      fifo_n = 0; epoch++;
      exp_if_pc = tgt & ~64'h3; exp_req_addr = tgt & ~64'h3;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    assert_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if ({imem_req_valid, if_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valids got=%b exp=00", {imem_req_valid, if_valid});
    end
    n_checks++;
    if (imem_req_addr !== 64'h0 || if_pc !== 64'h0 || if_inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_data got addr=%h pc=%h inst=%h exp 0", imem_req_addr, if_pc, if_inst);
    end
    release_reset();
  endtask

  task automatic test_basic();
    lat_min = 1; lat_max = 1; salt = 32'h0;
    repeat (20) do_cycle(0, 64'h0, 1, 1);
    n_checks++;
    if (first_valid_cyc != 3) begin
      n_fail++; $display("FAIL first_valid got=%0d exp=3", first_valid_cyc);
    end
    n_checks++;
    if (n_deliv < 15) begin
      n_fail++; $display("FAIL basic_throughput got=%0d exp>=15", n_deliv);
    end
  endtask

  task automatic test_full();
    int n0, k;
    assert_reset(); release_reset();
    lat_min = 1; lat_max = 1;
    repeat (12) do_cycle(0, 64'h0, 1, 0);
    n_checks++;
    if (n_req != 4 || last_rv !== 1'b0) begin
      n_fail++; $display("FAIL full_reqs got=%0d valid=%b exp=4 valid=0", n_req, last_rv);
    end
    n_checks++;
    if (last_ifv !== 1'b1 || last_ifpc !== 64'h0) begin
      n_fail++; $display("FAIL full_head got v=%b pc=%h exp v=1 pc=0", last_ifv, last_ifpc);
    end
    n0 = n_req; k = 0;
    while (n_req == n0 && k < 10) begin do_cycle(0, 64'h0, 1, 1); k++; end
    n_checks++;
    if (n_req == n0 || last_req_addr !== 64'h10) begin
      n_fail++; $display("FAIL full_resume got addr=%h reqs=%0d exp addr=10", last_req_addr, n_req - n0);
    end
    repeat (6) do_cycle(0, 64'h0, 1, 1);
  endtask

  task automatic reach_two_outstanding(input bit ifr);
    int k;
    k = 0;
    while (mq.size() != 2 && k < 20) begin do_cycle(0, 64'h0, 1, ifr); k++; end
    n_checks++;
    if (mq.size() != 2) begin
      n_fail++; $display("FAIL timeout_two_outstanding got=%0d exp=2", mq.size());
    end
  endtask

  task automatic test_flush();
    int d0, k;
    assert_reset(); release_reset();
    lat_min = 3; lat_max = 3;
    reach_two_outstanding(1);
    do_cycle(1, 64'h100, 1, 1);
    d0 = n_deliv; k = 0;
    while (n_deliv == d0 && k < 30) begin do_cycle(0, 64'h0, 1, 1); k++; end
    n_checks++;
    if (n_deliv == d0 || last_deliv_pc !== 64'h100) begin
      n_fail++; $display("FAIL flush_first_pc got=%h exp=100", last_deliv_pc);
    end
    repeat (6) do_cycle(0, 64'h0, 1, 1);
  endtask

  task automatic test_coincident();
    int k;
    assert_reset(); release_reset();
    lat_min = 2; lat_max = 2;
    k = 0;
    while (!(mq.size() == 2 && mq[0].due <= cyc && fifo_n > 0) && k < 30) begin
      do_cycle(0, 64'h0, 1, 0); k++;
    end
    n_checks++;
    if (k >= 30) begin n_fail++; $display("FAIL timeout_coincident got=%0d exp<30", k); end
    do_cycle(1, 64'h200, 1, 1);
    do_cycle(0, 64'h0, 1, 1);
    n_checks++;
    if (last_ifv !== 1'b0 || last_rv !== 1'b0) begin
      n_fail++; $display("FAIL coinc_flush got ifv=%b rv=%b exp 0 0", last_ifv, last_rv);
    end
    do_cycle(0, 64'h0, 1, 1);
    n_checks++;
    if (last_rv !== 1'b1 || last_addr !== 64'h200) begin
      n_fail++; $display("FAIL coinc_resume got rv=%b addr=%h exp 1 200", last_rv, last_addr);
    end
    repeat (8) do_cycle(0, 64'h0, 1, 1);
  endtask

  task automatic test_reset_in_flush();
    assert_reset(); release_reset();
    lat_min = 3; lat_max = 3;
    reach_two_outstanding(1);
    do_cycle(1, 64'h100, 1, 1);
    n_checks++;
    if (imem_req_addr !== 64'h100) begin
      n_fail++; $display("FAIL pre_reset_addr got=%h exp=100", imem_req_addr);
    end
    assert_reset();
    #1;
    n_checks++;
    if ({imem_req_valid, if_valid} !== 2'b00 || imem_req_addr !== 64'h0 || if_pc !== 64'h0 || if_inst !== 32'h0) begin
      n_fail++; $display("FAIL reset_in_flush got rv=%b iv=%b addr=%h exp all 0", imem_req_valid, if_valid, imem_req_addr);
    end
    release_reset();
    lat_min = 1; lat_max = 1;
    repeat (2) do_cycle(0, 64'h0, 1, 1);
    n_checks++;
    if (n_req != 1 || last_req_addr !== 64'h0) begin
      n_fail++; $display("FAIL restart got reqs=%0d addr=%h exp 1 0", n_req, last_req_addr);
    end
    repeat (8) do_cycle(0, 64'h0, 1, 1);
  endtask

  task automatic test_unaligned_stall();
    int n0;
    assert_reset(); release_reset();
    lat_min = 1; lat_max = 1;
    do_cycle(0, 64'h0, 0, 1);
    do_cycle(1, 64'h102, 0, 1);
    n0 = n_req;
    for (int i = 0; i < 3; i++) begin
      do_cycle(0, 64'h0, 0, 1);
      n_checks++;
      if (last_rv !== 1'b1 || last_addr !== 64'h100) begin
        n_fail++; $display("FAIL stall_hold got rv=%b addr=%h exp 1 100", last_rv, last_addr);
      end
    end
    do_cycle(0, 64'h0, 1, 1);
    n_checks++;
    if (n_req != n0 + 1 || last_req_addr !== 64'h100) begin
      n_fail++; $display("FAIL stall_handshake got n=%0d addr=%h exp 1 100", n_req - n0, last_req_addr);
    end
    do_cycle(0, 64'h0, 0, 1);
    n_checks++;
    if (last_addr !== 64'h104) begin
      n_fail++; $display("FAIL stall_next got=%h exp=104", last_addr);
    end
    repeat (6) do_cycle(0, 64'h0, 1, 1);
  endtask

  task automatic test_random();
    logic [63:0] tgt;
    bit br;
    assert_reset(); release_reset();
    salt = $urandom; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 800; i++) begin
      br  = ($urandom_range(99) < 3);
      tgt = ($urandom_range(3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15)))
                                     : {$urandom, $urandom};
      do_cycle(br, tgt, $urandom_range(99) < 70, $urandom_range(99) < 60);
    end
    n_checks++;
    if (n_deliv < 100) begin
      n_fail++; $display("FAIL random_progress got=%0d exp>=100", n_deliv);
    end
  endtask

  initial begin
    zero_inputs();
    test_reset();
    test_basic();
    test_full();
    test_flush();
    test_coincident();
    test_reset_in_flush();
    test_unaligned_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
